stack_call_ctrl: RTL

//  Sequencer that drives the special-register write channels for SP, LR and PC (plus a data-memory port) to execute PUSH, POP, CALL (BL) and RET.

---
 rtl/stack_call_ctrl_pkg.sv | 45 ++++
 rtl/stack_call_ctrl_bounds_chk.sv | 44 ++++
 rtl/stack_call_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_call_ctrl_pkg.sv
// ============================================================================
// Module : scc_pkg
// Brief  : Shared encodings for the stack/call controller: op codes, fault
//          codes, FSM states and the word size.
//          Build option: STACK_CALL_NESTED_LR_EN (CALL/RET save/restore LR
//          through the stack).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scc_pkg;

    localparam int WORD_BYTES = 4;

`ifdef STACK_CALL_NESTED_LR_EN
    localparam bit NESTED_LR_EN = 1'b1;
`else
    localparam bit NESTED_LR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        FC_NONE      = 2'd0,
        FC_OVERFLOW  = 2'd1,
        FC_UNDERFLOW = 2'd2,
        FC_MISALIGN  = 2'd3
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_WR = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_COMMIT = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/stack_call_ctrl_bounds_chk.sv
// ============================================================================
// Module : stack_bounds_chk
// Brief  : Combinational SP legality check for an incoming op: alignment,
//          push overflow below STACK_LIMIT, pop underflow at STACK_BASE.
//          Build option: STACK_CALL_NESTED_LR_EN (CALL counts as a push,
//          RET as a pop).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_bounds_chk
    import scc_pkg::*;
#(
    parameter int              DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_BASE  = 'h0000_1000,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 'h0000_0800
) (
    input  logic [DATA_W-1:0] i_sp,
    input  op_e               i_op,
    output fault_e            o_fault_code
);

    logic [DATA_W-1:0] w_sp_dec;
    logic              w_is_push;
    logic              w_is_pop;

    // Priority-ordered fault classification; misalignment dominates.
    always_comb begin
        w_sp_dec     = i_sp - DATA_W'(WORD_BYTES);
        w_is_push    = (i_op == OP_PUSH) || (NESTED_LR_EN && (i_op == OP_CALL));
        w_is_pop     = (i_op == OP_POP)  || (NESTED_LR_EN && (i_op == OP_RET));
        o_fault_code = FC_NONE;
        if (i_sp[1:0] != 2'b00) begin
            o_fault_code = FC_MISALIGN;
        end else if (w_is_push && (w_sp_dec < STACK_LIMIT)) begin
            o_fault_code = FC_OVERFLOW;
        end else if (w_is_pop && (i_sp == STACK_BASE)) begin
            o_fault_code = FC_UNDERFLOW;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stack_call_ctrl.sv
// ============================================================================
// Module : stack_call_ctrl
// Brief  : Sequencer executing PUSH/POP/CALL/RET by pulsing SP/LR/PC write
//          enables into the special register file and driving a data-memory
//          port for stack traffic.
//          Build option: STACK_CALL_NESTED_LR_EN (CALL pushes old LR, RET
//          pops it back).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stack_call_ctrl
    import scc_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_BASE  = 'h0000_1000,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 'h0000_0800
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic [DATA_W-1:0] op_target,
    input  logic [DATA_W-1:0] re_sp,
    input  logic [DATA_W-1:0] re_lr,
    input  logic [DATA_W-1:0] re_pc,
    output logic              wr_sp,
    output logic              wr_lr,
    output logic              wr_pc,
    output logic [DATA_W-1:0] wr_sp_data,
    output logic [DATA_W-1:0] wr_lr_data,
    output logic [DATA_W-1:0] wr_pc_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam logic [DATA_W-1:0] c_WORD = DATA_W'(WORD_BYTES);

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    fault_e            r_fault_code;
    logic [DATA_W-1:0] r_sp;
    logic [DATA_W-1:0] r_lr;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_target;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;

    op_e               w_op;
    fault_e            w_chk_code;
    logic              w_accept;
    logic              w_stack_push;

    assign w_op         = op_e'(op_code);
    assign w_accept     = op_valid & op_ready;
    assign w_stack_push = (w_op == OP_PUSH) || (w_op == OP_CALL);
    assign fault_code   = r_fault_code;

    stack_bounds_chk #(
        .DATA_W      (DATA_W),
        .STACK_BASE  (STACK_BASE),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_bounds_chk (
        .i_sp         (re_sp),
        .i_op         (w_op),
        .o_fault_code (w_chk_code)
    );

    // State register plus operand snapshot on accept and read-data capture on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_PUSH;
            r_fault_code <= FC_NONE;
            r_sp         <= '0;
            r_lr         <= '0;
            r_pc         <= '0;
            r_target     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op         <= w_op;
                r_fault_code <= w_chk_code;
                r_sp         <= re_sp;
                r_lr         <= re_lr;
                r_pc         <= re_pc;
                r_target     <= op_target;
                // Pushes (PUSH, nested CALL) write below SP; pops read at SP.
                r_mem_addr   <= w_stack_push ? (re_sp - c_WORD) : re_sp;
                r_mem_wdata  <= (w_op == OP_PUSH) ? op_wdata : re_lr;
            end
            if (mem_req && mem_ack) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Next-state decode and per-state output drive; data outputs are zero when idle.
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        wr_sp       = 1'b0;
        wr_lr       = 1'b0;
        wr_pc       = 1'b0;
        wr_sp_data  = '0;
        wr_lr_data  = '0;
        wr_pc_data  = '0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        pop_valid   = 1'b0;
        pop_data    = '0;
        fault       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (w_chk_code != FC_NONE) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        case (w_op)
                            OP_PUSH: w_state_nxt = ST_MEM_WR;
                            OP_POP:  w_state_nxt = ST_MEM_RD;
                            OP_CALL: w_state_nxt = NESTED_LR_EN ? ST_MEM_WR : ST_COMMIT;
                            default: w_state_nxt = NESTED_LR_EN ? ST_MEM_RD : ST_COMMIT;
                        endcase
                    end
                end
            end
            ST_MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_mem_addr;
                mem_wdata = r_mem_wdata;
                if (mem_ack) w_state_nxt = ST_COMMIT;
            end
            ST_MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_mem_addr;
                if (mem_ack) w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                case (r_op)
                    OP_PUSH: begin
                        wr_sp      = 1'b1;
                        wr_sp_data = r_sp - c_WORD;
                    end
                    OP_POP: begin
                        wr_sp      = 1'b1;
                        wr_sp_data = r_sp + c_WORD;
                        pop_valid  = 1'b1;
                        pop_data   = r_rdata;
                    end
                    OP_CALL: begin
                        wr_lr      = 1'b1;
                        wr_lr_data = r_pc + c_WORD;
                        wr_pc      = 1'b1;
                        wr_pc_data = r_target;
                        if (NESTED_LR_EN) begin
                            wr_sp      = 1'b1;
                            wr_sp_data = r_sp - c_WORD;
                        end
                    end
                    default: begin
                        wr_pc      = 1'b1;
                        wr_pc_data = r_lr;
                        if (NESTED_LR_EN) begin
                            wr_lr      = 1'b1;
                            wr_lr_data = r_rdata;
                            wr_sp      = 1'b1;
                            wr_sp_data = r_sp + c_WORD;
                        end
                    end
                endcase
            end
            ST_FAULT: begin
                fault       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire
